// File: rtl/keypad_pkg.sv
// Shared helpers and event-word layout for the keypad scanner and its event FIFO.
// The event word is {pressed, code}: the MSB is the level, the low KW bits are the key index.
package keypad_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int KW       = clog2(DEF_ROWS * DEF_COLS);
    localparam int EW       = KW + 1;

    typedef struct packed {
        logic          pressed;
        logic [KW-1:0] code;
    } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag for dropped pushes.
module key_event_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign valid = !empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            // NOTE: storage is reset too, so the head word reads as zero out of reset instead of X.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/keypad_scan_events.sv
// Row-scanning matrix keypad with per-key debounce; press/release events are queued in a FIFO.
// Each row is driven for one full divider slot and sampled at its end, then its keys are processed one per cycle.
module keypad_scan_events
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int CLK_DIV        = 5000,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [COLS-1:0]               col,
    output logic [ROWS-1:0]               row,
    output logic [ROWS*COLS-1:0]          key_state,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          evt_pressed,
    output logic [clog2(ROWS*COLS)-1:0]   evt_code,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int KEYS  = ROWS * COLS;
    localparam int CW    = clog2(KEYS);
    localparam int EVT_W = CW + 1;
    localparam int RW    = clog2(ROWS);
    localparam int CLW   = clog2(COLS);
    localparam int DW    = clog2(CLK_DIV);

    logic [COLS-1:0]  col_s1;
    logic [COLS-1:0]  col_s2;
    logic [DW-1:0]    div;
    logic [RW-1:0]    row_idx;
    logic [RW-1:0]    row_next;
    logic [COLS-1:0]  samp;
    logic [RW-1:0]    proc_row;
    logic [CLW-1:0]   proc_col;
    logic             proc_busy;
    logic [3:0]       cnt [KEYS];
    logic [CW-1:0]    proc_key;
    logic [3:0]       cnt_next;
    logic             change;
    logic             accept;
    logic [EVT_W-1:0] push_data;
    logic [EVT_W-1:0] head;

    assign row_next  = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    assign proc_key  = CW'(int'(proc_row) * COLS + int'(proc_col));
    assign cnt_next  = cnt[proc_key] + 4'd1;
    assign change    = samp[proc_col] != key_state[proc_key];
    assign accept    = proc_busy && change && (cnt_next == 4'(DEBOUNCE_SCANS));
    assign push_data = {~key_state[proc_key], proc_key};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1    <= '1;
            col_s2    <= '1;
            div       <= '0;
            row_idx   <= '0;
            row       <= ~(ROWS'(1));
            samp      <= '0;
            proc_row  <= '0;
            proc_col  <= '0;
            proc_busy <= 1'b0;
            key_state <= '0;
            for (int k = 0; k < KEYS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout, so every term on the right is the pre-edge value.
            col_s1 <= col;
            col_s2 <= col_s1;

            if (proc_busy) begin
                if (!change) begin
                    cnt[proc_key] <= '0;
                end else if (accept) begin
                    key_state[proc_key] <= ~key_state[proc_key];
                    cnt[proc_key]       <= '0;
                end else begin
                    cnt[proc_key] <= cnt_next;
                end
                if (proc_col == CLW'(COLS - 1)) begin
                    proc_busy <= 1'b0;
                end else begin
                    proc_col <= proc_col + 1'b1;
                end
            end

            // Slot end: capture the row that was driven all slot, then move on to the next one.
            if (div == DW'(CLK_DIV - 1)) begin
                div       <= '0;
                samp      <= ~col_s2;
                proc_row  <= row_idx;
                proc_col  <= '0;
                proc_busy <= 1'b1;
                row_idx   <= row_next;
                row       <= ~(ROWS'(1) << row_next);
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    key_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (push_data),
        .pop       (evt_ready),
        .valid     (evt_valid),
        .head      (head),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    assign {evt_pressed, evt_code} = head;

endmodule

// File: tb/tb_keypad_scan_events.sv
// Bench for keypad_scan_events: a keypad model drives col from row, expected events go through a scoreboard queue.
module tb_keypad_scan_events;
    import keypad_pkg::*;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int CLK_DIV = 8;
    localparam int DEB     = 3;
    localparam int DEPTH   = 4;
    localparam int SCAN    = ROWS * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [COLS-1:0]   col;
    logic [ROWS-1:0]   row;
    logic [15:0]       key_state;
    logic              evt_valid;
    logic              evt_ready = 1'b1;
    logic              evt_pressed;
    logic [KW-1:0]     evt_code;
    logic              overflow;
    logic              ovf_clr = 1'b0;
    logic [15:0]       keys = '0;

    key_event_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    keypad_scan_events #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col         (col),
        .row         (row),
        .key_state   (key_state),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_pressed (evt_pressed),
        .evt_code    (evt_code),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    // A held key pulls its column low only while its row is driven.
    always_comb begin
        col = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!row[r] && keys[r*COLS+c]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic key_event_t ev(input logic p, input int k);
        key_event_t e;
        e.pressed = p;
        e.code    = KW'(k);
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        keys      = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
    endtask

    // Returns just after the edge on which row r was sampled (row output moves to r+1).
    task automatic wait_sample(input int r, input string tag);
        logic [3:0] after;
        int n;
        after = ~(4'b0001 << ((r + 1) % ROWS));
        n = 0;
        while (row == after && n < 4 * SCAN) begin
            tick(1);
            n++;
        end
        while (row != after && n < 4 * SCAN) begin
            tick(1);
            n++;
        end
        if (n >= 4 * SCAN) begin
            check(tag, 32'(row), 32'(after));
        end
    endtask

    always @(negedge clk) begin : monitor
        key_event_t e;
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("evt_unexpected", 32'({evt_pressed, evt_code}), 32'h100);
            end else begin
                e = exp_q.pop_front();
                check("evt", 32'({evt_pressed, evt_code}), 32'(e));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [3:0] steps [4];
        steps[0] = 4'b1101;
        steps[1] = 4'b1011;
        steps[2] = 4'b0111;
        steps[3] = 4'b1110;

        // Reset state and row stepping
        tick(2);
        check("rst_row", 32'(row), 32'h0000_000e);
        check("rst_key_state", 32'(key_state), 32'h0);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(CLK_DIV);
            check("row_step", 32'(row), 32'(steps[i]));
        end

        // Clean press and release of key 9 (row 2, col 1)
        do_reset();
        keys[9] = 1'b1;
        exp_q.push_back(ev(1'b1, 9));
        tick(5 * SCAN);
        check("press_state", 32'(key_state), 32'h0000_0200);
        check("press_drained", 32'(exp_q.size()), 32'h0);
        keys[9] = 1'b0;
        exp_q.push_back(ev(1'b0, 9));
        tick(2 * SCAN - 4);
        check("release_hold", 32'(key_state), 32'h0000_0200);
        tick(SCAN + 16);
        check("release_state", 32'(key_state), 32'h0);
        check("release_drained", 32'(exp_q.size()), 32'h0);

        // Bounce: 2 scans on, 1 off, 2 on, off -> never accepted
        do_reset();
        keys[9] = 1'b1;
        tick(2 * SCAN);
        keys[9] = 1'b0;
        tick(SCAN);
        keys[9] = 1'b1;
        tick(2 * SCAN);
        check("bounce_mid", 32'(key_state), 32'h0);
        keys[9] = 1'b0;
        tick(4 * SCAN);
        check("bounce_state", 32'(key_state), 32'h0);
        check("bounce_valid", 32'(evt_valid), 32'h0);

        // Two keys in one row change together
        do_reset();
        evt_ready = 1'b0;
        keys[0] = 1'b1;
        keys[3] = 1'b1;
        exp_q.push_back(ev(1'b1, 0));
        exp_q.push_back(ev(1'b1, 3));
        tick(4 * SCAN);
        check("sim_state", 32'(key_state), 32'h0000_0009);
        check("sim_valid", 32'(evt_valid), 32'h1);
        check("sim_head", 32'({evt_pressed, evt_code}), 32'h10);
        evt_ready = 1'b1;
        tick(4);
        check("sim_drained", 32'(exp_q.size()), 32'h0);
        check("sim_empty", 32'(evt_valid), 32'h0);

        // Overflow: five presses into a four-entry FIFO
        do_reset();
        evt_ready = 1'b0;
        keys[7:4] = 4'hf;
        for (int k = 4; k < 8; k++) begin
            exp_q.push_back(ev(1'b1, k));
        end
        tick(4 * SCAN);
        check("ovf_not_yet", 32'(overflow), 32'h0);
        keys[8] = 1'b1;
        tick(4 * SCAN);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_state", 32'(key_state), 32'h0000_01f0);
        evt_ready = 1'b1;
        tick(6);
        evt_ready = 1'b0;
        check("ovf_drained", 32'(exp_q.size()), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);

        // Refill to full, then push on the same cycle as a pop
        keys[7:4] = 4'h0;
        for (int k = 4; k < 8; k++) begin
            exp_q.push_back(ev(1'b0, k));
        end
        tick(4 * SCAN);
        check("full_valid", 32'(evt_valid), 32'h1);
        check("full_no_ovf", 32'(overflow), 32'h0);
        wait_sample(2, "sample_timeout");
        keys[8] = 1'b0;
        exp_q.push_back(ev(1'b0, 8));
        wait_sample(2, "sample_timeout");
        wait_sample(2, "sample_timeout");
        wait_sample(2, "sample_timeout");
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("pushpop_no_ovf", 32'(overflow), 32'h0);
        check("pushpop_state", 32'(key_state), 32'h0);
        evt_ready = 1'b1;
        tick(8);
        check("pushpop_drained", 32'(exp_q.size()), 32'h0);
        check("pushpop_ovf_final", 32'(overflow), 32'h0);

        // Asynchronous reset in the middle of a slot
        do_reset();
        evt_ready = 1'b0;
        keys[1:0] = 2'b11;
        exp_q.push_back(ev(1'b1, 0));
        exp_q.push_back(ev(1'b1, 1));
        tick(4 * SCAN);
        check("mid_valid", 32'(evt_valid), 32'h1);
        wait_sample(1, "sample_timeout");
        keys[5] = 1'b1;
        wait_sample(1, "sample_timeout");
        wait_sample(1, "sample_timeout");
        tick(3);
        #2;
        rst_n = 1'b0;
        keys[1:0] = 2'b00;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'h0);
        check("mid_rst_state", 32'(key_state), 32'h0);
        check("mid_rst_row", 32'(row), 32'h0000_000e);
        tick(1);
        rst_n = 1'b1;
        tick(70);
        check("mid_no_early", 32'(key_state), 32'h0);
        exp_q.push_back(ev(1'b1, 5));
        evt_ready = 1'b1;
        tick(30);
        check("mid_after", 32'(key_state), 32'h0000_0020);
        check("mid_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
